// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready pipeline bus: opaque payload plus PC and exception sideband.
// master drives the entry and valid; slave returns ready.
interface pipe_stage_elastic_if #(
  parameter int DATA_W = 128,
  parameter int EXC_W  = 5
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [31:0]       pc;
  logic              exc;
  logic [EXC_W-1:0]  exccode;
  logic [31:0]       badva;

  modport master (output valid, data, pc, exc, exccode, badva, input ready);
  modport slave  (input valid, data, pc, exc, exccode, badva, output ready);
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with flush and first-exception-wins merge.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with a registered in-side ready.
module pipe_stage_elastic #(
  parameter int          DATA_W = 128,
  parameter int          EXC_W  = 5,
  parameter logic [31:0] RST_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  pipe_stage_elastic_if.slave  in_if,
  pipe_stage_elastic_if.master out_if,
  input  logic                 loc_exc_i,
  input  logic [EXC_W-1:0]     loc_exccode_i,
  input  logic [31:0]          loc_badva_i,
  output logic [1:0]           occupancy_o
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [31:0]       pc;
    logic              exc;
    logic [EXC_W-1:0]  exccode;
    logic [31:0]       badva;
  } entry_t;

  localparam entry_t RST_ENTRY = '{data: '0, pc: RST_PC, exc: 1'b0, exccode: '0, badva: '0};

  entry_t main_q, main_d;
  logic   main_valid_q, main_valid_d;
  entry_t in_entry;
  logic   in_ready;
  logic   in_fire;
  logic   out_fire;
  logic   clear;

  // An earlier stage's exception is older, so it wins over the local one.
  always_comb begin
    in_entry      = '0;
    in_entry.data = in_if.data;
    in_entry.pc   = in_if.pc;
    if (in_if.exc) begin
      in_entry.exc     = 1'b1;
      in_entry.exccode = in_if.exccode;
      in_entry.badva   = in_if.badva;
    end else if (loc_exc_i) begin
      in_entry.exc     = 1'b1;
      in_entry.exccode = loc_exccode_i;
      in_entry.badva   = loc_badva_i;
    end else begin
      in_entry.exc     = 1'b0;
      in_entry.exccode = '0;
      in_entry.badva   = in_if.pc;
    end
  end

  assign clear    = !rst || flush_i;
  assign out_fire = main_valid_q && out_if.ready;
  assign in_fire  = in_if.valid && in_ready && !flush_i;

`ifdef PIPE_STAGE_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;

  // Ready depends only on flops, so out_ready never reaches upstream combinationally.
  assign in_ready = rst && !skid_valid_q;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      if (out_fire) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid_q || out_fire) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
    if (clear) begin
      main_d       = RST_ENTRY;
      main_valid_d = 1'b0;
      skid_d       = RST_ENTRY;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    skid_q       <= skid_d;
    skid_valid_q <= skid_valid_d;
  end

  assign occupancy_o = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
`else
  assign in_ready = rst && (!main_valid_q || out_if.ready);

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    if (in_fire) begin
      main_d       = in_entry;
      main_valid_d = 1'b1;
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
    if (clear) begin
      main_d       = RST_ENTRY;
      main_valid_d = 1'b0;
    end
  end

  assign occupancy_o = {1'b0, main_valid_q};
`endif

  always_ff @(posedge clk) begin
    main_q       <= main_d;
    main_valid_q <= main_valid_d;
  end

  assign in_if.ready    = in_ready;
  assign out_if.valid   = main_valid_q;
  assign out_if.data    = main_q.data;
  assign out_if.pc      = main_q.pc;
  assign out_if.exc     = main_valid_q && main_q.exc;
  assign out_if.exccode = main_q.exccode;
  assign out_if.badva   = main_q.badva;

endmodule
